ssb_sync_ctrl: RTL
==================

// Module: ssb_sync_ctrl
// PURPOSE
//   Timing controller between N_CH parallel PSS correlator/peak-detector chains and FFT_demod.
//   - Picks the strongest simultaneous peak and latches its N_id_2.
//   - Waits a runtime-programmable number of samples, then starts SSB demodulation.
//   - Issues per-symbol strobes for the 4-symbol SSB, then tracks lock with a timeout.
//   - Replaces the fixed single-channel sync_wait_counter / enable_fft path.
// PARAMETERS
//   N_CH          3      number of correlator channels (one per N_id_2 hypothesis)
//   SCORE_DW      32     width of each correlator peak score (unsigned)
//   SYM_LEN       256    FFT length in input samples
//   CP_LEN        18     cyclic prefix length in input samples
//   WAIT_W        8      width of cfg_wait_i
//   LOCK_TIMEOUT  20480  valid samples without a same-channel peak before lock is dropped
// PORTS
//   clk_i             in   1              clock
//   reset_ni          in   1              asynchronous reset, active low
//   s_axis_in_tvalid  in   1              input sample strobe; all sample counters advance only on it
//   peak_detected_i   in   N_CH           per-channel peak pulses, single cycle
//   peak_score_i      in   N_CH*SCORE_DW  per-channel score; channel c occupies [c*SCORE_DW +: SCORE_DW]
//   cfg_wait_i        in   WAIT_W         samples between the peak and ssb_start_o (CP_LEN - detection delay)
//   ssb_start_o       out  1              1-cycle pulse; drives FFT_demod SSB_start_i
//   symbol_start_o    out  1              1-cycle pulse at each of the 4 SSB symbol boundaries
//   symbol_idx_o      out  2              SSB symbol index, valid with symbol_start_o
//   PBCH_start_o      out  1              1-cycle pulse at the start of symbols 1 and 3
//   SSS_start_o       out  1              1-cycle pulse at the start of symbol 2
//   N_id_2_o          out  $clog2(N_CH)   latched channel index
//   N_id_2_valid_o    out  1              high from the first latch until return to SEARCH
//   locked_o          out  1              high in TRACK
//   lost_o            out  1              1-cycle pulse on timeout
// BEHAVIOUR
//   - All outputs are registered. Asynchronous reset forces every output to 0 and the FSM to SEARCH.
//   - States: SEARCH, WAIT, SSB, TRACK.
//   - SEARCH, on a cycle with any peak_detected_i bit set:
//     - Select the asserted channel with the highest score; ties go to the lowest index.
//     - Latch N_id_2_o; assert N_id_2_valid_o.
//     - If cfg_wait_i == 0: go to SSB, ssb_start_o on the next cycle. Otherwise go to WAIT with wcnt = 0.
//   - WAIT:
//     - wcnt increments on each s_axis_in_tvalid.
//     - When wcnt reaches cfg_wait_i - 1 on a valid cycle, the next cycle pulses ssb_start_o and enters SSB.
//     - cfg_wait_i is sampled once, at WAIT entry.
//   - SSB:
//     - scnt counts valid samples, 0 .. SYM_LEN+CP_LEN-1, per symbol; sym counts 0..3.
//     - symbol_start_o and symbol_idx_o pulse at scnt == 0 of each symbol. Symbol 0 pulse coincides with ssb_start_o.
//     - PBCH_start_o pulses with symbols 1 and 3; SSS_start_o pulses with symbol 2.
//     - After the last sample of symbol 3: go to TRACK and clear tcnt.
//   - TRACK:
//     - locked_o = 1; tcnt increments on each valid sample.
//     - A peak on the latched channel, ignoring scores, re-enters WAIT and clears tcnt.
//     - Peaks on other channels are ignored.
//     - When tcnt reaches LOCK_TIMEOUT-1 on a valid cycle: pulse lost_o, clear N_id_2_valid_o and locked_o, go to SEARCH.
//     - A peak and a timeout in the same cycle: the peak wins; no lost_o.
//   - Peaks arriving in WAIT or SSB are ignored; there is no re-arm mid-SSB.
//   - Counter widths use $clog2 of their maximum. No wrap occurs, because every counter resets on its terminal value.
//   - Output latency: from peak pulse to ssb_start_o = cfg_wait_i valid samples + 1 clock.
//     The cfg_wait_i == 0 case is exactly 1 clock.
// STRUCTURE
//   - ssb_sync_pkg holds:
//     - the state_t enum (SEARCH, WAIT, SSB, TRACK);
//     - SSB_SYMS = 4;
//     - the symbol-role constants SYM_PSS = 0, SYM_PBCH0 = 1, SYM_SSS = 2, SYM_PBCH1 = 3.
//   - Sub-module peak_argmax (N_CH, SCORE_DW): combinational masked argmax. Outputs idx and any.
// TESTING
//   1. Peak on ch1 only, score 100, cfg_wait = 3, tvalid always 1:
//      - ssb_start_o exactly 4 cycles after the peak; N_id_2_o = 1.
//      - SSS_start_o 2*(SYM_LEN+CP_LEN) cycles after ssb_start_o.
//   2. Simultaneous peaks, ch0 = 50, ch2 = 80, then ch0 = ch2 = 80 in a new run:
//      - First run N_id_2_o = 2; tie run N_id_2_o = 0.
//   3. tvalid every 2nd cycle, cfg_wait = 3:
//      - ssb_start_o after 3 valid samples.
//      - symbol_start_o spacing = 2*(SYM_LEN+CP_LEN) clocks; symbol_idx_o goes 0, 1, 2, 3.
//   4. Lock, then no peaks:
//      - lost_o pulses after LOCK_TIMEOUT valid samples in TRACK; locked_o and N_id_2_valid_o drop.
//      - A ch0 peak while latched to ch1 in TRACK is ignored.
//   5. Peak during SSB is ignored. TRACK peak coinciding with the timeout gives re-WAIT with no lost_o.
//   6. reset_ni asserted mid-SSB, asynchronously between clock edges:
//      - Outputs go 0 immediately; FSM in SEARCH after release.
//      - cfg_wait = 0 then gives ssb_start_o 1 clock after the peak.

Source files
------------

// File: rtl/ssb_sync_pkg.sv
// ----------------------------------------------------------------------------
// ssb_sync_pkg
//   Shared types and constants for the SSB timing controller.
//   - state_t    : controller states (SEARCH, WAIT, SSB, TRACK)
//   - SSB_SYMS   : number of OFDM symbols in one SS/PBCH block
//   - SYM_*      : role of each symbol inside the block
//   - is_pbch_sym / is_sss_sym : map a symbol index to its role strobe
// ----------------------------------------------------------------------------
package ssb_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        WAIT   = 2'd1,
        SSB    = 2'd2,
        TRACK  = 2'd3
    } state_t;

    localparam int SSB_SYMS = 4;

    localparam logic [1:0] SYM_PSS   = 2'd0;
    localparam logic [1:0] SYM_PBCH0 = 2'd1;
    localparam logic [1:0] SYM_SSS   = 2'd2;
    localparam logic [1:0] SYM_PBCH1 = 2'd3;

    // Index of the final symbol of the block.
    localparam logic [1:0] SYM_LAST  = 2'(SSB_SYMS - 1);

    function automatic logic is_pbch_sym(input logic [1:0] idx);
        return (idx == SYM_PBCH0) || (idx == SYM_PBCH1);
    endfunction

    function automatic logic is_sss_sym(input logic [1:0] idx);
        return (idx == SYM_SSS);
    endfunction

endpackage

// File: rtl/peak_argmax.sv
// ----------------------------------------------------------------------------
// peak_argmax
//   Combinational masked argmax over N_CH unsigned scores.
//   Ports:
//     mask_i  [N_CH]            : channels taking part (peak pulses)
//     score_i [N_CH*SCORE_DW]   : channel c at [c*SCORE_DW +: SCORE_DW]
//     idx_o   [$clog2(N_CH)]    : winning channel (0 when any_o is low)
//     any_o                     : at least one mask bit set
//   Ties resolve to the lowest index because a later channel only wins on a
//   strictly greater score.
// ----------------------------------------------------------------------------
module peak_argmax #(
    parameter int N_CH     = 3,
    parameter int SCORE_DW = 32
) (
    input  logic [N_CH-1:0]          mask_i,
    input  logic [N_CH*SCORE_DW-1:0] score_i,
    output logic [$clog2(N_CH)-1:0]  idx_o,
    output logic                     any_o
);

    localparam int IDX_W = $clog2(N_CH);

    logic [IDX_W-1:0]    best_idx;
    logic [SCORE_DW-1:0] best_score;
    logic                found;

    always_comb begin
        best_idx   = '0;
        best_score = '0;
        found      = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (mask_i[c] &&
                (!found || (score_i[c*SCORE_DW +: SCORE_DW] > best_score))) begin
                best_idx   = IDX_W'(c);
                best_score = score_i[c*SCORE_DW +: SCORE_DW];
                found      = 1'b1;
            end
        end
    end

    assign idx_o = best_idx;
    assign any_o = found;

endmodule

// File: rtl/ssb_sync_ctrl.sv
// ----------------------------------------------------------------------------
// ssb_sync_ctrl
//   Timing controller between N_CH PSS correlator/peak-detector chains and
//   FFT_demod. Picks the strongest simultaneous peak, latches its N_id_2,
//   waits a programmable number of samples, then emits the SSB start and the
//   per-symbol strobes, and finally tracks lock with a timeout.
//   Ports:
//     clk_i, reset_ni     : clock, asynchronous active-low reset
//     s_axis_in_tvalid    : input sample strobe
//     peak_detected_i     : per-channel single-cycle peak pulses
//     peak_score_i        : per-channel unsigned scores
//     cfg_wait_i          : samples from peak to ssb_start_o
//     ssb_start_o         : pulse, start of SSB demodulation
//     symbol_start_o      : pulse at each SSB symbol boundary
//     symbol_idx_o        : symbol index, valid with symbol_start_o
//     PBCH_start_o        : pulse at symbols 1 and 3
//     SSS_start_o         : pulse at symbol 2
//     N_id_2_o            : latched channel index
//     N_id_2_valid_o      : high from latch until return to SEARCH
//     locked_o            : high in TRACK
//     lost_o              : pulse on lock timeout
//     dbg_state_o         : current controller state (state_t encoding)
//
//   Sample strobe: s_axis_in_tvalid is a pure qualifier with no ready; every
//   sample counter here advances only on cycles where it is high, and the
//   block never back-pressures the sample source.
// ----------------------------------------------------------------------------
module ssb_sync_ctrl
    import ssb_sync_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int SCORE_DW     = 32,
    parameter int SYM_LEN      = 256,
    parameter int CP_LEN       = 18,
    parameter int WAIT_W       = 8,
    parameter int LOCK_TIMEOUT = 20480
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     s_axis_in_tvalid,
    input  logic [N_CH-1:0]          peak_detected_i,
    input  logic [N_CH*SCORE_DW-1:0] peak_score_i,
    input  logic [WAIT_W-1:0]        cfg_wait_i,
    output logic                     ssb_start_o,
    output logic                     symbol_start_o,
    output logic [1:0]               symbol_idx_o,
    output logic                     PBCH_start_o,
    output logic                     SSS_start_o,
    output logic [$clog2(N_CH)-1:0]  N_id_2_o,
    output logic                     N_id_2_valid_o,
    output logic                     locked_o,
    output logic                     lost_o,
    output logic [1:0]               dbg_state_o
);

    localparam int IDX_W   = $clog2(N_CH);
    localparam int SYM_TOT = SYM_LEN + CP_LEN;
    localparam int SC_W    = $clog2(SYM_TOT);
    localparam int TC_W    = $clog2(LOCK_TIMEOUT);

    // Terminal values; each counter returns to zero on reaching its own.
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYM_TOT - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(LOCK_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Peak selection
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] pk_idx;
    logic             pk_any;

    peak_argmax #(
        .N_CH     (N_CH),
        .SCORE_DW (SCORE_DW)
    ) u_argmax (
        .mask_i  (peak_detected_i),
        .score_i (peak_score_i),
        .idx_o   (pk_idx),
        .any_o   (pk_any)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wcnt_q;
    logic [SC_W-1:0]   scnt_q;
    logic [1:0]        sym_q;
    logic [TC_W-1:0]   tcnt_q;

    logic              ssb_start_q;
    logic              symbol_start_q;
    logic [1:0]        symbol_idx_q;
    logic              pbch_start_q;
    logic              sss_start_q;
    logic [IDX_W-1:0]  n_id_2_q;
    logic              n_id_2_valid_q;
    logic              locked_q;
    logic              lost_q;

    // Next symbol index and "wait is over" test, shared by the FSM arms.
    logic [1:0] sym_d;
    logic       wait_done_d;
    logic       track_peak_d;

    assign sym_d        = sym_q + 2'd1;
    assign wait_done_d  = (wcnt_q == (wait_q - 1'b1));
    // In TRACK only the latched hypothesis can refresh the timing; scores
    // play no role there.
    assign track_peak_d = peak_detected_i[n_id_2_q];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= SEARCH;
            wait_q         <= '0;
            wcnt_q         <= '0;
            scnt_q         <= '0;
            sym_q          <= '0;
            tcnt_q         <= '0;
            ssb_start_q    <= 1'b0;
            symbol_start_q <= 1'b0;
            symbol_idx_q   <= '0;
            pbch_start_q   <= 1'b0;
            sss_start_q    <= 1'b0;
            n_id_2_q       <= '0;
            n_id_2_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            ssb_start_q    <= 1'b0;
            symbol_start_q <= 1'b0;
            pbch_start_q   <= 1'b0;
            sss_start_q    <= 1'b0;
            lost_q         <= 1'b0;

            case (state_q)
                SEARCH: begin
                    if (pk_any) begin
                        n_id_2_q       <= pk_idx;
                        n_id_2_valid_q <= 1'b1;
                        if (cfg_wait_i == '0) begin
                            // Zero wait: the block starts on the next cycle.
                            state_q        <= SSB;
                            ssb_start_q    <= 1'b1;
                            symbol_start_q <= 1'b1;
                            symbol_idx_q   <= SYM_PSS;
                            scnt_q         <= '0;
                            sym_q          <= SYM_PSS;
                        end else begin
                            state_q <= WAIT;
                            wcnt_q  <= '0;
                            wait_q  <= cfg_wait_i;
                        end
                    end
                end

                WAIT: begin
                    // wait_q is frozen at entry so a reprogrammed cfg_wait_i
                    // cannot shift a block that is already scheduled.
                    if (s_axis_in_tvalid) begin
                        if (wait_done_d) begin
                            state_q        <= SSB;
                            ssb_start_q    <= 1'b1;
                            symbol_start_q <= 1'b1;
                            symbol_idx_q   <= SYM_PSS;
                            scnt_q         <= '0;
                            sym_q          <= SYM_PSS;
                            wcnt_q         <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end

                SSB: begin
                    // The sample seen on the ssb_start_o cycle is sample 0
                    // of symbol 0; peaks are not looked at until TRACK.
                    if (s_axis_in_tvalid) begin
                        if (scnt_q == SC_LAST) begin
                            scnt_q <= '0;
                            if (sym_q == SYM_LAST) begin
                                state_q  <= TRACK;
                                tcnt_q   <= '0;
                                locked_q <= 1'b1;
                            end else begin
                                sym_q          <= sym_d;
                                symbol_start_q <= 1'b1;
                                symbol_idx_q   <= sym_d;
                                pbch_start_q   <= is_pbch_sym(sym_d);
                                sss_start_q    <= is_sss_sym(sym_d);
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end

                TRACK: begin
                    // A same-channel peak takes priority over the timeout
                    // that may expire on the very same cycle.
                    if (track_peak_d) begin
                        locked_q <= 1'b0;
                        tcnt_q   <= '0;
                        if (cfg_wait_i == '0) begin
                            state_q        <= SSB;
                            ssb_start_q    <= 1'b1;
                            symbol_start_q <= 1'b1;
                            symbol_idx_q   <= SYM_PSS;
                            scnt_q         <= '0;
                            sym_q          <= SYM_PSS;
                        end else begin
                            state_q <= WAIT;
                            wcnt_q  <= '0;
                            wait_q  <= cfg_wait_i;
                        end
                    end else if (s_axis_in_tvalid) begin
                        if (tcnt_q == TC_LAST) begin
                            state_q        <= SEARCH;
                            tcnt_q         <= '0;
                            lost_q         <= 1'b1;
                            locked_q       <= 1'b0;
                            n_id_2_valid_q <= 1'b0;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign ssb_start_o    = ssb_start_q;
    assign symbol_start_o = symbol_start_q;
    assign symbol_idx_o   = symbol_idx_q;
    assign PBCH_start_o   = pbch_start_q;
    assign SSS_start_o    = sss_start_q;
    assign N_id_2_o       = n_id_2_q;
    assign N_id_2_valid_o = n_id_2_valid_q;
    assign locked_o       = locked_q;
    assign lost_o         = lost_q;
    assign dbg_state_o    = state_q;

endmodule
